// File: rtl/csr_reg_file.sv
// CSR register file for the HDC core.
// Single-beat host requests over valid/ready; the response follows one cycle
// after the request fires. Drives static core configuration, one-cycle command
// pulses and instruction-memory writes. Returns core status on reads.
//
// Register index map (csr_req_addr_i is a register index):
//   0 CORE_SET        [0] start pulse, [1] busy (RO), [2] seq_test,
//                     [4:3] ima_mux, [5] imb_mux, [6] clear pulse
//   1 AM_NUM_PREDICT  [31:0]
//   2 AM_PREDICT (RO) [7:0] prediction, [8] valid (cleared by read)
//   3 INST_CTRL       [0] wr_mode, [1] dbg_mode, [2] clear pulse
//   4 INST_WRITE_ADDR [7:0], advances after each memory write strobe
//   5 INST_WRITE_DATA [31:0], strobes memory when wr_mode is set
//   6 INST_RDDBG_ADDR [7:0]
//   7 INST_PC (RO)    [7:0]
//   8 INST_AT_ADDR(RO)[31:0]
//   9 INST_LOOP_CTRL  [1:0]
//  10 LOOP_JUMP       [23:0]
//  11 LOOP_END        [23:0]
//  12 LOOP_COUNT      [23:0]
module csr_reg_file #(
    parameter int CsrDataWidth  = 32,
    parameter int InstAddrWidth = 8,
    parameter int InstWidth     = 32,
    parameter int PredWidth     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CsrDataWidth-1:0]    csr_req_addr_i,
    input  logic [CsrDataWidth-1:0]    csr_req_data_i,
    input  logic                       csr_req_write_i,
    input  logic                       csr_req_valid_i,
    output logic                       csr_req_ready_o,
    output logic [CsrDataWidth-1:0]    csr_rsp_data_o,
    output logic                       csr_rsp_valid_o,
    input  logic                       csr_rsp_ready_i,
    output logic                       core_start_o,
    input  logic                       core_busy_i,
    output logic                       core_seq_test_o,
    output logic [1:0]                 core_ima_mux_o,
    output logic                       core_imb_mux_o,
    output logic                       core_clr_o,
    output logic [CsrDataWidth-1:0]    am_num_pred_o,
    input  logic [PredWidth-1:0]       am_pred_i,
    input  logic                       am_pred_valid_i,
    output logic                       inst_wr_mode_o,
    output logic                       inst_dbg_mode_o,
    output logic                       inst_clr_o,
    output logic [InstAddrWidth-1:0]   inst_wr_addr_o,
    output logic [InstWidth-1:0]       inst_wr_data_o,
    output logic                       inst_wr_en_o,
    output logic [InstAddrWidth-1:0]   inst_rddbg_addr_o,
    input  logic [InstAddrWidth-1:0]   inst_pc_i,
    input  logic [InstWidth-1:0]       inst_at_addr_i,
    output logic [1:0]                 loop_mode_o,
    output logic [3*InstAddrWidth-1:0] loop_jump_o,
    output logic [3*InstAddrWidth-1:0] loop_end_o,
    output logic [3*InstAddrWidth-1:0] loop_count_o
);

    localparam int LoopWidth = 3 * InstAddrWidth;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    fire_s;
    logic                    wr_s;
    logic                    rd_s;
    logic [CsrDataWidth-1:0] rdata_s;
    logic                    pred_valid_r;
    logic [PredWidth-1:0]    pred_r;

    assign fire_s = csr_req_valid_i & csr_req_ready_o;
    assign wr_s   = fire_s & csr_req_write_i;
    assign rd_s   = fire_s & ~csr_req_write_i;

    // Handshake state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: accept in IDLE, hold the response until the host takes it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) state_s = ST_RESP;
                else        state_s = ST_IDLE;
            end
            ST_RESP: begin
                if (csr_rsp_ready_i) state_s = ST_IDLE;
                else                 state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Read mux over the current register contents; unmapped indices read zero.
    always_comb begin
        rdata_s = {CsrDataWidth{1'b0}};
        case (csr_req_addr_i)
            32'd0:   rdata_s = {26'd0, core_imb_mux_o, core_ima_mux_o,
                                core_seq_test_o, core_busy_i, 1'b0};
            32'd1:   rdata_s = am_num_pred_o;
            32'd2:   rdata_s = CsrDataWidth'({pred_valid_r, pred_r});
            32'd3:   rdata_s = {30'd0, inst_dbg_mode_o, inst_wr_mode_o};
            32'd4:   rdata_s = CsrDataWidth'(inst_wr_addr_o);
            32'd5:   rdata_s = CsrDataWidth'(inst_wr_data_o);
            32'd6:   rdata_s = CsrDataWidth'(inst_rddbg_addr_o);
            32'd7:   rdata_s = CsrDataWidth'(inst_pc_i);
            32'd8:   rdata_s = CsrDataWidth'(inst_at_addr_i);
            32'd9:   rdata_s = {30'd0, loop_mode_o};
            32'd10:  rdata_s = CsrDataWidth'(loop_jump_o);
            32'd11:  rdata_s = CsrDataWidth'(loop_end_o);
            32'd12:  rdata_s = CsrDataWidth'(loop_count_o);
            default: rdata_s = {CsrDataWidth{1'b0}};
        endcase
    end

    // Handshake outputs and response data, registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_req_ready_o <= 1'b1;
            csr_rsp_valid_o <= 1'b0;
            csr_rsp_data_o  <= {CsrDataWidth{1'b0}};
        end else begin
            csr_req_ready_o <= (state_s == ST_IDLE);
            csr_rsp_valid_o <= (state_s == ST_RESP);
            if (fire_s) begin
                csr_rsp_data_o <= csr_req_write_i ? {CsrDataWidth{1'b0}} : rdata_s;
            end
        end
    end

    // Prediction latch: a new valid pulse beats the clear-on-read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_r <= 1'b0;
            pred_r       <= {PredWidth{1'b0}};
        end else if (am_pred_valid_i) begin
            pred_valid_r <= 1'b1;
            pred_r       <= am_pred_i;
        end else if (rd_s && (csr_req_addr_i == 32'd2)) begin
            pred_valid_r <= 1'b0;
        end
    end

    // Writable configuration registers and one-cycle command pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_start_o      <= 1'b0;
            core_clr_o        <= 1'b0;
            core_seq_test_o   <= 1'b0;
            core_ima_mux_o    <= 2'd0;
            core_imb_mux_o    <= 1'b0;
            am_num_pred_o     <= {CsrDataWidth{1'b0}};
            inst_wr_mode_o    <= 1'b0;
            inst_dbg_mode_o   <= 1'b0;
            inst_clr_o        <= 1'b0;
            inst_wr_addr_o    <= {InstAddrWidth{1'b0}};
            inst_wr_data_o    <= {InstWidth{1'b0}};
            inst_wr_en_o      <= 1'b0;
            inst_rddbg_addr_o <= {InstAddrWidth{1'b0}};
            loop_mode_o       <= 2'd0;
            loop_jump_o       <= {LoopWidth{1'b0}};
            loop_end_o        <= {LoopWidth{1'b0}};
            loop_count_o      <= {LoopWidth{1'b0}};
        end else begin
            core_start_o <= 1'b0;
            core_clr_o   <= 1'b0;
            inst_clr_o   <= 1'b0;
            inst_wr_en_o <= 1'b0;
            // The write address advances once the strobe has been presented.
            if (inst_wr_en_o) begin
                inst_wr_addr_o <= inst_wr_addr_o + {{(InstAddrWidth-1){1'b0}}, 1'b1};
            end
            if (wr_s) begin
                case (csr_req_addr_i)
                    32'd0: begin
                        // Clear dominates start; start is dropped while the core is busy.
                        core_start_o    <= csr_req_data_i[0] & ~csr_req_data_i[6] & ~core_busy_i;
                        core_clr_o      <= csr_req_data_i[6];
                        core_seq_test_o <= csr_req_data_i[2];
                        core_ima_mux_o  <= csr_req_data_i[4:3];
                        core_imb_mux_o  <= csr_req_data_i[5];
                    end
                    32'd1:  am_num_pred_o <= csr_req_data_i;
                    32'd3: begin
                        inst_wr_mode_o  <= csr_req_data_i[0];
                        inst_dbg_mode_o <= csr_req_data_i[1];
                        inst_clr_o      <= csr_req_data_i[2];
                    end
                    32'd4:  inst_wr_addr_o    <= csr_req_data_i[InstAddrWidth-1:0];
                    32'd5: begin
                        inst_wr_data_o <= csr_req_data_i[InstWidth-1:0];
                        inst_wr_en_o   <= inst_wr_mode_o;
                    end
                    32'd6:  inst_rddbg_addr_o <= csr_req_data_i[InstAddrWidth-1:0];
                    32'd9:  loop_mode_o       <= csr_req_data_i[1:0];
                    32'd10: loop_jump_o       <= csr_req_data_i[LoopWidth-1:0];
                    32'd11: loop_end_o        <= csr_req_data_i[LoopWidth-1:0];
                    32'd12: loop_count_o      <= csr_req_data_i[LoopWidth-1:0];
                    default: begin
                        // Read-only or unmapped: the write is dropped.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_reg_file.sv
// Randomized self-checking bench for csr_reg_file against a register-map model.
module tb_csr_reg_file;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] csr_req_addr_i, csr_req_data_i;
    logic        csr_req_write_i, csr_req_valid_i, csr_req_ready_o;
    logic [31:0] csr_rsp_data_o;
    logic        csr_rsp_valid_o, csr_rsp_ready_i;
    logic        core_start_o, core_busy_i, core_seq_test_o, core_imb_mux_o, core_clr_o;
    logic [1:0]  core_ima_mux_o;
    logic [31:0] am_num_pred_o;
    logic [7:0]  am_pred_i;
    logic        am_pred_valid_i;
    logic        inst_wr_mode_o, inst_dbg_mode_o, inst_clr_o, inst_wr_en_o;
    logic [7:0]  inst_wr_addr_o, inst_rddbg_addr_o, inst_pc_i;
    logic [31:0] inst_wr_data_o, inst_at_addr_i;
    logic [1:0]  loop_mode_o;
    logic [23:0] loop_jump_o, loop_end_o, loop_count_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_reg [0:15];
    logic [7:0]  m_waddr;
    logic        m_pv;
    logic [7:0]  m_pval;

    csr_reg_file dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .csr_req_addr_i(csr_req_addr_i), .csr_req_data_i(csr_req_data_i),
        .csr_req_write_i(csr_req_write_i), .csr_req_valid_i(csr_req_valid_i),
        .csr_req_ready_o(csr_req_ready_o), .csr_rsp_data_o(csr_rsp_data_o),
        .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rsp_ready_i(csr_rsp_ready_i),
        .core_start_o(core_start_o), .core_busy_i(core_busy_i),
        .core_seq_test_o(core_seq_test_o), .core_ima_mux_o(core_ima_mux_o),
        .core_imb_mux_o(core_imb_mux_o), .core_clr_o(core_clr_o),
        .am_num_pred_o(am_num_pred_o), .am_pred_i(am_pred_i),
        .am_pred_valid_i(am_pred_valid_i), .inst_wr_mode_o(inst_wr_mode_o),
        .inst_dbg_mode_o(inst_dbg_mode_o), .inst_clr_o(inst_clr_o),
        .inst_wr_addr_o(inst_wr_addr_o), .inst_wr_data_o(inst_wr_data_o),
        .inst_wr_en_o(inst_wr_en_o), .inst_rddbg_addr_o(inst_rddbg_addr_o),
        .inst_pc_i(inst_pc_i), .inst_at_addr_i(inst_at_addr_i),
        .loop_mode_o(loop_mode_o), .loop_jump_o(loop_jump_o),
        .loop_end_o(loop_end_o), .loop_count_o(loop_count_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Writable bits of each register index (0 = read-only or unmapped)
    function automatic logic [31:0] wmask(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0000_003C;
            32'd1:   return 32'hFFFF_FFFF;
            32'd3:   return 32'h0000_0003;
            32'd5:   return 32'hFFFF_FFFF;
            32'd6:   return 32'h0000_00FF;
            32'd9:   return 32'h0000_0003;
            32'd10, 32'd11, 32'd12: return 32'h00FF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a)
            32'd0:   return m_reg[0] | {30'd0, core_busy_i, 1'b0};
            32'd2:   return {23'd0, m_pv, m_pval};
            32'd4:   return {24'd0, m_waddr};
            32'd7:   return {24'd0, inst_pc_i};
            32'd8:   return inst_at_addr_i;
            default: return (a <= 32'd12) ? m_reg[a[3:0]] : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
        m_waddr = 8'd0;
        m_pv    = 1'b0;
        m_pval  = 8'd0;
    endtask

    task automatic check_static();
        check("core_cfg", {28'd0, core_seq_test_o, core_ima_mux_o, core_imb_mux_o},
              {28'd0, m_reg[0][2], m_reg[0][4:3], m_reg[0][5]});
        check("am_num_pred", am_num_pred_o, m_reg[1]);
        check("inst_mode", {30'd0, inst_dbg_mode_o, inst_wr_mode_o}, m_reg[3]);
        check("inst_wr_addr", {24'd0, inst_wr_addr_o}, {24'd0, m_waddr});
        check("inst_wr_data", inst_wr_data_o, m_reg[5]);
        check("rddbg_addr", {24'd0, inst_rddbg_addr_o}, m_reg[6]);
        check("loop_mode", {30'd0, loop_mode_o}, m_reg[9]);
        check("loop_jump", {8'd0, loop_jump_o}, m_reg[10]);
        check("loop_end", {8'd0, loop_end_o}, m_reg[11]);
        check("loop_count", {8'd0, loop_count_o}, m_reg[12]);
    endtask

    // One request/response; called and returns at posedge+1.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input int hold, input logic amv, input logic [7:0] amval);
        logic [31:0] exp_rd, rd;
        logic [3:0]  exp_p;
        int n;
        exp_rd = w ? 32'd0 : model_read(a);
        exp_p  = {w && a == 32'd0 && d[0] && !d[6] && !core_busy_i,
                  w && a == 32'd0 && d[6],
                  w && a == 32'd3 && d[2],
                  w && a == 32'd5 && m_reg[3][0]};
        n = 0;
        while (!csr_req_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", {31'd0, csr_req_ready_o}, 32'd1);
        csr_req_addr_i = a; csr_req_data_i = d; csr_req_write_i = w; csr_req_valid_i = 1'b1;
        am_pred_valid_i = amv; am_pred_i = amval;
        @(posedge clk); #1;
        csr_req_valid_i = 1'b0; csr_req_write_i = 1'b0; am_pred_valid_i = 1'b0;
        if (hold > 0) csr_rsp_ready_i = 1'b0;
        @(negedge clk);
        check("rsp_handshake", {30'd0, csr_rsp_valid_o, csr_req_ready_o}, 32'd2);
        check("rsp_data", csr_rsp_data_o, exp_rd);
        check("pulses", {28'd0, core_start_o, core_clr_o, inst_clr_o, inst_wr_en_o}, {28'd0, exp_p});
        if (exp_p[0]) begin
            check("strobe_addr", {24'd0, inst_wr_addr_o}, {24'd0, m_waddr});
            check("strobe_data", inst_wr_data_o, d);
        end
        rd = csr_rsp_data_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_handshake", {30'd0, csr_rsp_valid_o, csr_req_ready_o}, 32'd2);
            check("hold_data", csr_rsp_data_o, rd);
        end
        csr_rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("pulse_drop", {28'd0, core_start_o, core_clr_o, inst_clr_o, inst_wr_en_o}, 32'd0);
        check("back_idle", {30'd0, csr_rsp_valid_o, csr_req_ready_o}, 32'd1);
        // Model update
        if (w && a == 32'd4) m_waddr = d[7:0];
        else if (w) m_reg[a[3:0]] = (a <= 32'd12) ? ((m_reg[a[3:0]] & ~wmask(a)) | (d & wmask(a))) : m_reg[a[3:0]];
        if (exp_p[0]) m_waddr = m_waddr + 8'd1;
        if (!w && a == 32'd2) m_pv = 1'b0;
        if (amv) begin m_pv = 1'b1; m_pval = amval; end
        check_static();
    endtask

    task automatic am_pulse(input logic [7:0] v);
        am_pred_valid_i = 1'b1; am_pred_i = v;
        @(posedge clk); #1;
        am_pred_valid_i = 1'b0;
        m_pv = 1'b1; m_pval = v;
    endtask

    initial begin
        rst_ni = 1'b0;
        csr_req_addr_i = 32'd0; csr_req_data_i = 32'd0; csr_req_write_i = 1'b0;
        csr_req_valid_i = 1'b0; csr_rsp_ready_i = 1'b1; core_busy_i = 1'b0;
        am_pred_i = 8'd0; am_pred_valid_i = 1'b0; inst_pc_i = 8'd0; inst_at_addr_i = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_handshake", {30'd0, csr_rsp_valid_o, csr_req_ready_o}, 32'd1);
        check_static();
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Every mapped register reads zero after reset
        for (int i = 0; i <= 12; i++) txn(i, 32'd0, 1'b0, 0, 1'b0, 8'd0);

        // CORE_SET with the core idle, then busy
        txn(32'd0, 32'h0000_0029, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd0, 32'd0, 1'b0, 0, 1'b0, 8'd0);
        core_busy_i = 1'b1;
        txn(32'd0, 32'h0000_0029, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd0, 32'd0, 1'b0, 0, 1'b0, 8'd0);
        txn(32'd0, 32'h0000_0041, 1'b1, 0, 1'b0, 8'd0);
        core_busy_i = 1'b0;
        txn(32'd0, 32'h0000_0041, 1'b1, 0, 1'b0, 8'd0);

        // Instruction writes wrapping the address
        txn(32'd3, 32'h0000_0001, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd4, 32'h0000_00FE, 1'b1, 0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) txn(32'd5, 32'hA000_0000 + i, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd4, 32'd0, 1'b0, 0, 1'b0, 8'd0);

        // Sticky prediction and clear-on-read
        am_pulse(8'h5A);
        txn(32'd2, 32'd0, 1'b0, 0, 1'b0, 8'd0);
        txn(32'd2, 32'd0, 1'b0, 0, 1'b0, 8'd0);
        am_pulse(8'h11);
        txn(32'd2, 32'd0, 1'b0, 0, 1'b1, 8'h77);
        txn(32'd2, 32'd0, 1'b0, 0, 1'b0, 8'd0);

        // Back-pressure, unmapped and read-only writes, loop registers
        txn(32'd1, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd1, 32'd0, 1'b0, 5, 1'b0, 8'd0);
        txn(32'd20, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd20, 32'd0, 1'b0, 2, 1'b0, 8'd0);
        txn(32'd2, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 8'd0);
        txn(32'd12, 32'h0003_0201, 1'b1, 0, 1'b0, 8'd0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            core_busy_i    = ($urandom_range(0, 3) == 0);
            inst_pc_i      = 8'($urandom);
            inst_at_addr_i = $urandom;
            if ($urandom_range(0, 3) == 0) am_pulse(8'($urandom));
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(13, 40)) : 32'($urandom_range(0, 12));
            txn(a, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 7) == 0), 8'($urandom));
        end
        core_busy_i = 1'b0; inst_pc_i = 8'd0; inst_at_addr_i = 32'd0;

        // Reset while a response is pending
        txn(32'd12, 32'h0003_0201, 1'b1, 0, 1'b0, 8'd0);
        csr_req_addr_i = 32'd12; csr_req_write_i = 1'b0; csr_req_valid_i = 1'b1;
        @(posedge clk); #1;
        csr_req_valid_i = 1'b0; csr_rsp_ready_i = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", {31'd0, csr_rsp_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("mid_reset_handshake", {30'd0, csr_rsp_valid_o, csr_req_ready_o}, 32'd1);
        check_static();
        @(posedge clk); #2;
        rst_ni = 1'b1; csr_rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("post_reset_valid", {31'd0, csr_rsp_valid_o}, 32'd0);
        txn(32'd12, 32'd0, 1'b0, 0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
